// File: rtl/display_pkg.sv
// display_pkg: shared types and sizing for the display refresh controller.
//   state_e      : sweep FSM states
//   NREGS/DATA_W : shape of the CPU register file being mirrored
//   ADDR_W       : register-file read address width
//   *_DEF        : default timing parameters for the top level
package display_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int NREGS  = 8;
   localparam int DATA_W = 4;
   localparam int ADDR_W = 3;

   localparam int REFRESH_DIV_DEF = 50000;
   localparam int STARVE_MAX_DEF  = 4;

endpackage

// File: rtl/refresh_divider.sv
// refresh_divider: free-running 0..REFRESH_DIV-1 counter.
//   clock  : system clock
//   resetn : asynchronous active-low reset, counter restarts at 0
//   tick   : one-cycle pulse during the wrap cycle (count == REFRESH_DIV-1)
module refresh_divider #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic clock,
   input  logic resetn,
   output logic tick
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == LAST);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/display_refresh_ctrl.sv
// display_refresh_ctrl: periodically copies the 8x4 CPU register file into
// shadow registers that feed the display writer, sharing the single
// register-file read port with the CPU.
//   clock, resetn            : clock, asynchronous active-low reset
//   cpu_rd_req/cpu_rd_addr   : CPU read request for the shared port
//   cpu_rd_gnt               : CPU owns the port this cycle (combinational)
//   rf_rd_addr/rf_rd_data    : shared register-file read port
//   freeze                   : holds off new sweeps (a running sweep finishes)
//   refresh_now              : request an immediate sweep
//   reg0..reg7               : shadow copies of registers 0..7
//   busy                     : sweep in progress (READ or DONE)
//   sweep_done               : one-cycle pulse after the last capture
module display_refresh_ctrl
   import display_pkg::*;
#(
   parameter int REFRESH_DIV = REFRESH_DIV_DEF,
   parameter int STARVE_MAX  = STARVE_MAX_DEF
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              cpu_rd_req,
   input  logic [ADDR_W-1:0] cpu_rd_addr,
   output logic              cpu_rd_gnt,
   output logic [ADDR_W-1:0] rf_rd_addr,
   input  logic [DATA_W-1:0] rf_rd_data,
   input  logic              freeze,
   input  logic              refresh_now,
   output logic [DATA_W-1:0] reg0,
   output logic [DATA_W-1:0] reg1,
   output logic [DATA_W-1:0] reg2,
   output logic [DATA_W-1:0] reg3,
   output logic [DATA_W-1:0] reg4,
   output logic [DATA_W-1:0] reg5,
   output logic [DATA_W-1:0] reg6,
   output logic [DATA_W-1:0] reg7,
   output logic              busy,
   output logic              sweep_done
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NREGS - 1);

   state_e                        state_q, state_d;
   logic [ADDR_W-1:0]             idx_q, idx_d;
   logic [SW-1:0]                 starve_q, starve_d;
   logic                          pending_q, pending_d;
   logic [NREGS-1:0][DATA_W-1:0]  shadow_q, shadow_d;

   logic tick;
   logic start;
   logic disp_win;

   refresh_divider #(.REFRESH_DIV(REFRESH_DIV)) u_div (
      .clock  (clock),
      .resetn (resetn),
      .tick   (tick)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      starve_d   = starve_q;
      shadow_d   = shadow_q;
      disp_win   = 1'b0;
      cpu_rd_gnt = cpu_rd_req;
      rf_rd_addr = cpu_rd_req ? cpu_rd_addr : '0;

      start = (state_q == IDLE) && pending_q && !freeze;
      // New requests win over the clear, so a request landing on the start
      // cycle (or during a sweep) yields exactly one follow-up sweep.
      pending_d = (pending_q && !start) || tick || refresh_now;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = READ;
               idx_d    = '0;
               starve_d = '0;
            end
         end
         READ: begin
            // CPU has priority until it has stalled the display STARVE_MAX
            // times in a row; then the display takes one cycle.
            disp_win   = (starve_q == STARVE_LIM) || !cpu_rd_req;
            cpu_rd_gnt = cpu_rd_req && !disp_win;
            if (disp_win) begin
               rf_rd_addr       = idx_q;
               shadow_d[idx_q]  = rf_rd_data;
               starve_d         = '0;
               idx_d            = idx_q + 1'b1;
               if (idx_q == LAST_IDX) state_d = DONE;
            end else begin
               rf_rd_addr = cpu_rd_addr;
               starve_d   = starve_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy       = (state_q != IDLE);
      sweep_done = (state_q == DONE);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         starve_q  <= '0;
         pending_q <= 1'b0;
         shadow_q  <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         starve_q  <= starve_d;
         pending_q <= pending_d;
         shadow_q  <= shadow_d;
      end
   end

   assign reg0 = shadow_q[0];
   assign reg1 = shadow_q[1];
   assign reg2 = shadow_q[2];
   assign reg3 = shadow_q[3];
   assign reg4 = shadow_q[4];
   assign reg5 = shadow_q[5];
   assign reg6 = shadow_q[6];
   assign reg7 = shadow_q[7];

endmodule

// File: tb/tb_display_refresh_ctrl.sv
// Bench for display_refresh_ctrl. Cycle k after reset release is the k-th
// clock period; inputs change 1 time unit after the rising edge, outputs are
// sampled on the falling edge. Expected shadow contents are queued when a
// sweep is set up and compared when sweep_done is seen.
module tb_display_refresh_ctrl;

   localparam int RDIV = 16;
   localparam int SMAX = 4;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       cpu_rd_req = 1'b0;
   logic [2:0] cpu_rd_addr = '0;
   logic       cpu_rd_gnt;
   logic [2:0] rf_rd_addr;
   logic [3:0] rf_rd_data;
   logic       freeze = 1'b0;
   logic       refresh_now = 1'b0;
   logic [3:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
   logic       busy, sweep_done;

   logic [3:0] rf [8];
   assign rf_rd_data = rf[rf_rd_addr];

   wire [31:0] regs = {reg7, reg6, reg5, reg4, reg3, reg2, reg1, reg0};

   display_refresh_ctrl #(.REFRESH_DIV(RDIV), .STARVE_MAX(SMAX)) dut (
      .clock(clock), .resetn(resetn),
      .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_gnt(cpu_rd_gnt),
      .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
      .freeze(freeze), .refresh_now(refresh_now),
      .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3),
      .reg4(reg4), .reg5(reg5), .reg6(reg6), .reg7(reg7),
      .busy(busy), .sweep_done(sweep_done)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [31:0] exp_q [$];

   typedef struct {
      logic       req;
      logic [2:0] addr;
      logic       e_gnt;
      logic [2:0] e_addr;
      logic       e_busy;
      logic       e_done;
   } vec_t;
   vec_t tbl [19];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc %0d got %h want %h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] rf_pack();
      logic [31:0] p;
      for (int i = 0; i < 8; i++) p[i*4 +: 4] = rf[i];
      return p;
   endfunction

   task automatic mon();
      if (sweep_done) begin
         chk("sweep_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) chk("sweep_regs", regs, exp_q.pop_front());
      end
   endtask

   task automatic to_neg(); @(negedge clock); mon(); endtask
   task automatic to_pos(); @(posedge clock); #1; cyc++; endtask
   task automatic step(); to_neg(); to_pos(); endtask
   task automatic at(input int c); while (cyc < c) step(); to_neg(); endtask

   task automatic do_reset(input bit check_state);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      resetn = 1'b0; freeze = 1'b0; refresh_now = 1'b0;
      cpu_rd_req = check_state; cpu_rd_addr = 3'd6;
      #1;
      if (check_state) begin
         chk("rst_regs", regs, 32'h0);
         chk("rst_busy_done", {busy, sweep_done}, 2'b00);
         chk("rst_gnt_addr", {cpu_rd_gnt, rf_rd_addr}, {1'b1, 3'd6});
      end
      cpu_rd_req = 1'b0; cpu_rd_addr = '0;
      @(posedge clock); #1;
      resetn = 1'b1;
      cyc = 1;
   endtask

   initial begin
      int bcnt, dcnt, first, b48;
      logic [31:0] a_val, c_val;

      // ---------------- reset + uncontested sweep ----------------
      for (int i = 0; i < 8; i++) rf[i] = 4'(i + 1);
      do_reset(1'b1);
      exp_q.push_back(rf_pack());
      bcnt = 0; dcnt = 0; first = 0;
      while (cyc <= 30) begin
         to_neg();
         if (busy) begin bcnt++; if (first == 0) first = cyc; end
         if (sweep_done) dcnt++;
         if (cyc == 18) chk("t1_regs_before", regs, 32'h0);
         if (cyc == 19) chk("t1_reg0_first", regs, 32'h0000_0001);
         if (cyc == 30) chk("t1_regs_after", regs, 32'h8765_4321);
         to_pos();
      end
      chk("t1_first_busy", 32'(first), 32'd18);
      chk("t1_busy_len", 32'(bcnt), 32'd9);
      chk("t1_done_cnt", 32'(dcnt), 32'd1);

      // ---------------- CPU contention, starvation guard ----------------
      for (int i = 0; i < 8; i++) rf[i] = 4'(8 - i);
      do_reset(1'b0);
      exp_q.push_back(rf_pack());
      cpu_rd_req = 1'b1; cpu_rd_addr = 3'd5;
      at(17); chk("t2_idle_busy", 32'(busy), 32'd0); to_pos();
      for (int n = 0; n < 42; n++) begin
         to_neg();
         if (n < 40) begin
            if (n % 5 == 4) chk("t2_disp_slot", {cpu_rd_gnt, rf_rd_addr}, {1'b0, 3'(n / 5)});
            else            chk("t2_cpu_slot", {cpu_rd_gnt, rf_rd_addr}, {1'b1, 3'd5});
         end else if (n == 40) begin
            chk("t2_done_at_41", {busy, sweep_done}, 2'b11);
         end else begin
            chk("t2_idle_after", 32'(busy), 32'd0);
         end
         to_pos();
      end
      cpu_rd_req = 1'b0;

      // ---------------- intermittent CPU (table-driven) ----------------
      for (int i = 0; i < 8; i++) rf[i] = 4'($urandom);
      tbl[0] = '{req: 1'b0, addr: 3'd3, e_gnt: 1'b0, e_addr: 3'd0, e_busy: 1'b0, e_done: 1'b0};
      for (int i = 1; i <= 16; i++) begin
         int n;
         n = i - 1;
         tbl[i].req    = (n % 2 == 0);
         tbl[i].addr   = 3'(7 - (n % 8));
         tbl[i].e_gnt  = tbl[i].req;
         tbl[i].e_addr = tbl[i].req ? tbl[i].addr : 3'(n / 2);
         tbl[i].e_busy = 1'b1;
         tbl[i].e_done = 1'b0;
      end
      tbl[17] = '{req: 1'b1, addr: 3'd4, e_gnt: 1'b1, e_addr: 3'd4, e_busy: 1'b1, e_done: 1'b1};
      tbl[18] = '{req: 1'b1, addr: 3'd2, e_gnt: 1'b1, e_addr: 3'd2, e_busy: 1'b0, e_done: 1'b0};
      do_reset(1'b0);
      exp_q.push_back(rf_pack());
      refresh_now = 1'b1; step(); refresh_now = 1'b0;
      for (int i = 0; i < 19; i++) begin
         cpu_rd_req = tbl[i].req; cpu_rd_addr = tbl[i].addr;
         to_neg();
         chk($sformatf("t3_vec%0d", i), {cpu_rd_gnt, rf_rd_addr, busy, sweep_done},
             {tbl[i].e_gnt, tbl[i].e_addr, tbl[i].e_busy, tbl[i].e_done});
         to_pos();
      end
      cpu_rd_req = 1'b0;

      // ---------------- freeze ----------------
      for (int i = 0; i < 8; i++) rf[i] = 4'($urandom);
      do_reset(1'b0);
      a_val = rf_pack();
      exp_q.push_back(a_val);
      refresh_now = 1'b1; step(); refresh_now = 1'b0;
      at(11); chk("t4_first_done", 32'(sweep_done), 32'd1); to_pos();
      freeze = 1'b1;
      for (int i = 0; i < 8; i++) rf[i] = 4'hF;
      bcnt = 0;
      while (cyc <= 40) begin to_neg(); if (busy) bcnt++; to_pos(); end
      chk("t4_frozen_busy", 32'(bcnt), 32'd0);
      freeze = 1'b0;
      to_neg(); chk("t4_release_idle", 32'(busy), 32'd0); chk("t4_held_regs", regs, a_val); to_pos();
      exp_q.push_back(32'hFFFF_FFFF);
      to_neg(); chk("t4_start_next", 32'(busy), 32'd1); to_pos();
      step();
      freeze = 1'b1;
      at(50); chk("t4_midfreeze_done", 32'(sweep_done), 32'd1); to_pos();
      freeze = 1'b0;

      // ---------------- refresh_now while busy ----------------
      for (int i = 0; i < 8; i++) rf[i] = 4'($urandom);
      do_reset(1'b0);
      exp_q.push_back(rf_pack()); exp_q.push_back(rf_pack());
      while (cyc < 21) step();
      refresh_now = 1'b1; step(); refresh_now = 1'b0;
      at(26); chk("t5_done1", 32'(sweep_done), 32'd1); to_pos();
      to_neg(); chk("t5_idle_gap", 32'(busy), 32'd0); to_pos();
      to_neg(); chk("t5_second_start", 32'(busy), 32'd1); to_pos();
      at(36); chk("t5_done2", 32'(sweep_done), 32'd1); to_pos();

      // double pulse merges into one extra sweep (third comes from divider)
      do_reset(1'b0);
      for (int k = 0; k < 3; k++) exp_q.push_back(rf_pack());
      dcnt = 0; b48 = 0;
      while (cyc <= 49) begin
         refresh_now = (cyc == 21) || (cyc == 23);
         to_neg();
         if (sweep_done) dcnt++;
         if (cyc == 48) b48 = busy;
         to_pos();
      end
      refresh_now = 1'b0;
      chk("t5_double_done_cnt", 32'(dcnt), 32'd3);
      chk("t5_double_idle48", 32'(b48), 32'd0);

      // ---------------- async reset mid-sweep ----------------
      for (int i = 0; i < 8; i++) rf[i] = 4'($urandom);
      do_reset(1'b0);
      c_val = rf_pack();
      at(22); chk("t6_partial", regs[15:0], c_val[15:0]); to_pos();
      resetn = 1'b0;
      #1;
      chk("t6_rst_regs", regs, 32'h0);
      chk("t6_rst_busy_done", {busy, sweep_done}, 2'b00);
      to_neg();
      @(posedge clock); #1;
      resetn = 1'b1; cyc = 1;
      exp_q.push_back(c_val);
      at(17); chk("t6_no_early", 32'(busy), 32'd0); to_pos();
      to_neg(); chk("t6_restart", 32'(busy), 32'd1); to_pos();
      at(26); chk("t6_done", 32'(sweep_done), 32'd1); to_pos();

      chk("final_queue", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

endmodule
